// File: rtl/debug_scan_sequencer_if.sv
// debug_scan_sequencer_if: valid/ready byte stream carrying scan frames out of the sequencer
interface debug_scan_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/debug_scan_sequencer.sv
// debug_scan_sequencer: scans debug mux selectors and streams snapshots; DEBUG_SCAN_FRAMING_EN adds A5 header and XOR checksum
module debug_scan_sequencer #(
  parameter int NUM_SEL       = 11,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic [7:0]                    debug_config_out,
  output logic                          debug_en,
  input  logic [7:0]                    debug_select_in,
  debug_scan_sequencer_if.master        tx,
  output logic                          frame_done
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0] LAST = 8'(NUM_SEL - 1);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, SETTLE, SEND, CHK, DONE} state_t;
  state_t state;
  logic [7:0] idx;
  logic [CW-1:0] cnt;
  logic xfer;
`ifdef DEBUG_SCAN_FRAMING_EN
  logic [7:0] chk;
`endif
  assign xfer = tx.tx_valid && tx.tx_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      debug_en         <= 1'b0;
      debug_config_out <= 8'h00;
      tx.tx_data       <= 8'h00;
      tx.tx_valid      <= 1'b0;
      frame_done       <= 1'b0;
      idx              <= 8'h00;
      cnt              <= '0;
`ifdef DEBUG_SCAN_FRAMING_EN
      chk              <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      debug_en   <= 1'b0;
      case (state)
        IDLE: begin
          idx <= 8'h00;
          if (start) begin
            busy <= 1'b1;
`ifdef DEBUG_SCAN_FRAMING_EN
            state       <= HDR;
            tx.tx_data  <= 8'hA5;
            tx.tx_valid <= 1'b1;
            chk         <= 8'h00;
`else
            state            <= LOAD;
            debug_en         <= 1'b1;
            debug_config_out <= 8'h00;
`endif
          end
        end
`ifdef DEBUG_SCAN_FRAMING_EN
        HDR: if (xfer) begin
          tx.tx_valid      <= 1'b0;
          state            <= LOAD;
          debug_en         <= 1'b1;
          debug_config_out <= idx;
        end
`endif
        LOAD: begin
          state <= SETTLE;
          cnt   <= CW'(SETTLE_CYCLES);
        end
        SETTLE: begin
          if (cnt == CW'(1)) begin
            tx.tx_data  <= debug_select_in;
            tx.tx_valid <= 1'b1;
            state       <= SEND;
`ifdef DEBUG_SCAN_FRAMING_EN
            chk         <= chk ^ debug_select_in;
`endif
          end else
            cnt <= cnt - CW'(1);
        end
        SEND: if (xfer) begin
          if (idx == LAST) begin
`ifdef DEBUG_SCAN_FRAMING_EN
            state      <= CHK;
            tx.tx_data <= chk;
`else
            tx.tx_valid <= 1'b0;
            state       <= DONE;
            frame_done  <= 1'b1;
`endif
          end else begin
            tx.tx_valid      <= 1'b0;
            idx              <= idx + 8'd1;
            debug_config_out <= idx + 8'd1;
            debug_en         <= 1'b1;
            state            <= LOAD;
          end
        end
`ifdef DEBUG_SCAN_FRAMING_EN
        CHK: if (xfer) begin
          tx.tx_valid <= 1'b0;
          state       <= DONE;
          frame_done  <= 1'b1;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_scan_sequencer.sv
// tb_debug_scan_sequencer: directed frames against a two-register debug mux model
module tb_debug_scan_sequencer;
  localparam int NS = 11;
`ifdef DEBUG_SCAN_FRAMING_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif
  logic clk = 1'b0;
  logic rst, start, busy, debug_en, frame_done, tx_ready;
  logic [7:0] cfg_out;
  logic [7:0] sel_q = 8'h00;
  logic [7:0] mux_cfg = 8'h00;
  logic [7:0] pot [16];
  int cyc = 0;
  int passed = 0, total = 0;
  int en_cnt = 0, done_cnt = 0, done_at = -1;
  logic [7:0] got [$];
  debug_scan_sequencer_if tx_if ();
  assign tx_if.tx_ready = tx_ready;
  debug_scan_sequencer #(.NUM_SEL(NS), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .debug_config_out(cfg_out), .debug_en(debug_en), .debug_select_in(sel_q),
    .tx(tx_if.master), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (debug_en) mux_cfg <= cfg_out;
    sel_q <= mux_cfg == 8'd10 ? 8'h5A : mux_cfg < 8'd10 ? pot[mux_cfg[3:0]] : 8'h00;
  end
  always @(negedge clk) begin
    if (tx_if.tx_valid && tx_ready) got.push_back(tx_if.tx_data);
    if (debug_en) en_cnt = en_cnt + 1;
    if (frame_done) begin done_cnt = done_cnt + 1; done_at = cyc; end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, debug_en, 0);
    check({tag, "_cfg"}, cfg_out, 0);
    check({tag, "_data"}, tx_if.tx_data, 0);
    check({tag, "_valid"}, tx_if.tx_valid, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask
  task automatic run_frame(input string tag, input int stall_len, input bit mid, input bit live);
    int s, n0, e0, d0, left, lcyc;
    logic [7:0] exp [$];
    logic [7:0] x, b;
    n0 = got.size(); e0 = en_cnt; d0 = done_cnt; left = stall_len; lcyc = -10; x = 8'h00;
    for (int i = 0; i < NS; i++) begin
      b = i == NS - 1 ? 8'h5A : (live && i == 2) ? 8'h07 : 8'(i + 1);
      x ^= b;
      exp.push_back(b);
    end
`ifdef DEBUG_SCAN_FRAMING_EN
    exp.push_front(8'hA5);
    exp.push_back(x);
`endif
    @(posedge clk); #1;
    start = 1'b1; s = cyc;
    while (done_cnt == d0 && cyc < s + 300) begin
      @(posedge clk); #1;
      start = mid && cyc == s + 10;
      if (cyc == s + 1) check({tag, "_busy_on"}, busy, 1);
      if (live) begin
        if (debug_en && cfg_out == 8'd2) lcyc = cyc;
        if (cyc == lcyc + 1) pot[2] = 8'h07;
        if (cyc == lcyc + 3) pot[2] = 8'h0F;
      end
      if (left > 0 && tx_if.tx_valid && int'(got.size()) - n0 == 3 + M) begin
        tx_ready = 1'b0;
        left--;
        check({tag, "_stall_data"}, tx_if.tx_data, 8'h04);
        check({tag, "_stall_en"}, debug_en, 0);
      end else tx_ready = 1'b1;
    end
    tx_ready = 1'b1;
    start = 1'b0;
    pot[2] = 8'h03;
    check({tag, "_done_cyc"}, done_at - s, 45 + 2 * M + stall_len);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_idle_cyc"}, cyc - s, 46 + 2 * M + stall_len);
    check({tag, "_en_cnt"}, en_cnt - e0, NS);
    check({tag, "_len"}, int'(got.size()) - n0, exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_b%0d", tag, i), n0 + i < int'(got.size()) ? got[n0 + i] : 8'hxx, exp[i]);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_one_frame"}, done_cnt - d0, 1);
    check({tag, "_valid_off"}, tx_if.tx_valid, 0);
  endtask
  task automatic reset_test();
    int s, d0;
    bit hit;
    d0 = done_cnt; hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; s = cyc;
    while (!hit && cyc < s + 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      hit = debug_en && cfg_out == 8'd6;
    end
    check("rst_reach_s6", hit, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("midrst");
    repeat (50) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) pot[k] = k < 10 ? 8'(k + 1) : 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    run_frame("basic", 0, 0, 0);
    run_frame("stall", 5, 0, 0);
    run_frame("midstart", 0, 1, 0);
    reset_test();
    run_frame("after_rst", 0, 0, 0);
    run_frame("live", 0, 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
